// File: rtl/async_fifo_level.sv
// Dual-clock FIFO with Gray-coded pointer crossing, registered occupancy levels,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module async_fifo_level #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ADDRSIZE    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AFULL_TH    = (1 << ADDRSIZE) - 4,
  parameter int unsigned AEMPTY_TH   = 4
) (
  input  logic                wclk,
  input  logic                rrst_n,
  input  logic                rclk,
  input  logic                winc,
  input  logic [WIDTH-1:0]    wdata,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow,
  input  logic                rinc,
  output logic [WIDTH-1:0]    rdata,
  output logic                rvalid,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  localparam int unsigned DEPTH = 1 << ADDRSIZE;
  localparam int unsigned PW    = ADDRSIZE + 1;
  localparam int unsigned AW    = ADDRSIZE;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = int'(PW) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Reset: asserted asynchronously, released through two flops per clock domain
  logic [1:0] wrst_sync_q;
  logic [1:0] rrst_sync_q;
  logic       wrst_n_c;
  logic       rrst_n_c;

  always_ff @(posedge wclk or negedge rrst_n) begin
    if (!rrst_n) wrst_sync_q <= 2'b00;
    else         wrst_sync_q <= {wrst_sync_q[0], 1'b1};
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) rrst_sync_q <= 2'b00;
    else         rrst_sync_q <= {rrst_sync_q[0], 1'b1};
  end

  assign wrst_n_c = wrst_sync_q[1];
  assign rrst_n_c = rrst_sync_q[1];

  logic [WIDTH-1:0] mem_q [DEPTH];

  // ---------------- write domain ----------------
  logic [PW-1:0]                   wbin_q, wbin_d;
  logic [PW-1:0]                   wgray_q, wgray_d;
  logic [SYNC_STAGES-1:0][PW-1:0]  wq_rgray_q;
  logic [PW-1:0]                   wlevel_q, wlevel_d;
  logic                            wfull_q, wfull_d;
  logic                            walmost_full_q, walmost_full_d;
  logic                            woverflow_q, woverflow_d;
  logic                            w_acc_c;

  logic [PW-1:0]                   rgray_q;

  // Write level is pessimistic: it uses a stale (synchronised) read pointer
  always_comb begin
    w_acc_c        = winc && !wfull_q;
    wbin_d         = wbin_q + PW'(w_acc_c);
    wgray_d        = bin2gray(wbin_d);
    wlevel_d       = wbin_d - gray2bin(wq_rgray_q[SYNC_STAGES-1]);
    wfull_d        = (wlevel_d == PW'(DEPTH));
    walmost_full_d = (wlevel_d >= PW'(AFULL_TH));
    woverflow_d    = woverflow_q | (winc & wfull_q);
  end

  always_ff @(posedge wclk or negedge wrst_n_c) begin
    if (!wrst_n_c) begin
      wbin_q         <= '0;
      wgray_q        <= '0;
      wq_rgray_q     <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      woverflow_q    <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wgray_q        <= wgray_d;
      wq_rgray_q     <= {wq_rgray_q[SYNC_STAGES-2:0], rgray_q};
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      woverflow_q    <= woverflow_d;
    end
  end

  // Storage is deliberately not reset
  always_ff @(posedge wclk) begin
    if (w_acc_c) mem_q[wbin_q[AW-1:0]] <= wdata;
  end

  // ---------------- read domain ----------------
  logic [PW-1:0]                   rbin_q, rbin_d;
  logic [PW-1:0]                   rgray_d;
  logic [SYNC_STAGES-1:0][PW-1:0]  rq_wgray_q;
  logic [PW-1:0]                   rlevel_q, rlevel_d;
  logic                            rempty_q, rempty_d;
  logic                            ralmost_empty_q, ralmost_empty_d;
  logic                            runderflow_q, runderflow_d;
  logic                            rvalid_q, rvalid_d;
  logic [WIDTH-1:0]                rdata_q, rdata_d;
  logic                            r_acc_c;

  // Read level is pessimistic: it uses a stale (synchronised) write pointer
  always_comb begin
    r_acc_c         = rinc && !rempty_q;
    rbin_d          = rbin_q + PW'(r_acc_c);
    rgray_d         = bin2gray(rbin_d);
    rlevel_d        = gray2bin(rq_wgray_q[SYNC_STAGES-1]) - rbin_d;
    rempty_d        = (rlevel_d == '0);
    ralmost_empty_d = (rlevel_d <= PW'(AEMPTY_TH));
    runderflow_d    = runderflow_q | (rinc & rempty_q);
    rvalid_d        = r_acc_c;
    rdata_d         = r_acc_c ? mem_q[rbin_q[AW-1:0]] : rdata_q;
  end

  always_ff @(posedge rclk or negedge rrst_n_c) begin
    if (!rrst_n_c) begin
      rbin_q          <= '0;
      rgray_q         <= '0;
      rq_wgray_q      <= '0;
      rlevel_q        <= '0;
      rempty_q        <= 1'b1;
      ralmost_empty_q <= 1'b1;
      runderflow_q    <= 1'b0;
      rvalid_q        <= 1'b0;
      rdata_q         <= '0;
    end else begin
      rbin_q          <= rbin_d;
      rgray_q         <= rgray_d;
      rq_wgray_q      <= {rq_wgray_q[SYNC_STAGES-2:0], wgray_q};
      rlevel_q        <= rlevel_d;
      rempty_q        <= rempty_d;
      ralmost_empty_q <= ralmost_empty_d;
      runderflow_q    <= runderflow_d;
      rvalid_q        <= rvalid_d;
      rdata_q         <= rdata_d;
    end
  end

  assign wfull         = wfull_q;
  assign walmost_full  = walmost_full_q;
  assign wlevel        = wlevel_q;
  assign woverflow     = woverflow_q;
  assign rdata         = rdata_q;
  assign rvalid        = rvalid_q;
  assign rempty        = rempty_q;
  assign ralmost_empty = ralmost_empty_q;
  assign rlevel        = rlevel_q;
  assign runderflow    = runderflow_q;

  // Occupancy can never exceed the array size in either domain
  a_wlevel_bound: assert property (@(posedge wclk) disable iff (!wrst_n_c)
    wlevel_q <= PW'(DEPTH));
  a_rlevel_bound: assert property (@(posedge rclk) disable iff (!rrst_n_c)
    rlevel_q <= PW'(DEPTH));

endmodule

// File: doc/async_fifo_level.md
ASYNC_FIFO_LEVEL -- requirements
Module: async_fifo_level

Interface
REQ-001 WIDTH, 8, data word width in bits (>=1).
REQ-002 ADDRSIZE, 4, address bits; DEPTH = 2**ADDRSIZE words (ADDRSIZE >= 2).
REQ-003 SYNC_STAGES, 2, flops per Gray-pointer synchroniser (2..4).
REQ-004 AFULL_TH, DEPTH-4, write-side level at or above which walmost_full SHALL assert (1..DEPTH).
REQ-005 AEMPTY_TH, 4, read-side level at or below which ralmost_empty SHALL assert (0..DEPTH-1).
REQ-006 wclk  in  1  write clock.
REQ-007 rrst_n  in  1  reset, asynchronous, active-low; clock wclk; also clears all read-domain state.
REQ-008 rclk  in  1  read clock, asynchronous to wclk.
REQ-009 winc  in  1  write request, sampled on rising wclk.
REQ-010 wdata  in  WIDTH  write data, captured with an accepted write.
REQ-011 wfull  out  1  FIFO full, wclk domain, registered.
REQ-012 walmost_full  out  1  wlevel >= AFULL_TH, registered.
REQ-013 wlevel  out  ADDRSIZE+1  occupancy seen by the write side, 0..DEPTH.
REQ-014 woverflow  out  1  sticky: write attempted while full.
REQ-015 rinc  in  1  read request, sampled on rising rclk.
REQ-016 rdata  out  WIDTH  registered read data.
REQ-017 rvalid  out  1  one-rclk pulse: rdata holds a newly read word.
REQ-018 rempty  out  1  FIFO empty, rclk domain, registered.
REQ-019 ralmost_empty  out  1  rlevel <= AEMPTY_TH, registered.
REQ-020 rlevel  out  ADDRSIZE+1  occupancy seen by the read side, 0..DEPTH.
REQ-021 runderflow  out  1  sticky: read attempted while empty.

Function
REQ-022 Pointers SHALL be ADDRSIZE+1-bit binary counters with registered Gray copies; only Gray values cross domains, each through SYNC_STAGES flops.
REQ-023 A write SHALL be accepted when winc=1 and wfull=0; the word is stored at wbin[ADDRSIZE-1:0] and wbin increments, wrapping modulo 2**(ADDRSIZE+1).
REQ-024 A read SHALL be accepted when rinc=1 and rempty=0; on that rclk edge rdata loads mem[rbin[ADDRSIZE-1:0]], rbin increments, and rvalid is 1 for exactly the following cycle (latency 1 rclk).
REQ-025 rdata SHALL hold its last value when no read is accepted.
REQ-026 wlevel SHALL register (wbin_next - bin(wq_rptr)) modulo 2**(ADDRSIZE+1); rlevel SHALL register (bin(rq_wptr) - rbin_next) likewise; both are pessimistic (write side overstates, read side understates).
REQ-027 wfull SHALL register (wlevel_next == DEPTH); rempty SHALL register (rlevel_next == 0).
REQ-028 walmost_full and ralmost_empty SHALL be computed from the same next-level values in the same cycle as wfull/rempty.
REQ-029 winc while wfull SHALL set woverflow, store nothing, and leave wbin unchanged; rinc while rempty SHALL set runderflow, leave rdata/rbin unchanged, rvalid=0.
REQ-030 Flags SHALL clear only on reset.
REQ-031 Simultaneous accepted read and write in their own domains SHALL both complete; a slot freed by a read SHALL become writable no later than SYNC_STAGES+1 wclk edges after the read.
REQ-032 A written word SHALL clear rempty no later than SYNC_STAGES+1 rclk edges after the write edge.
REQ-033 Pointer wrap-around (MSB toggle) SHALL not disturb level, full or empty computation.

Reset
REQ-034 rrst_n low SHALL immediately clear wbin, rbin, Gray pointers, synchronisers, wlevel, rlevel, rvalid, rdata, woverflow, runderflow, walmost_full; set rempty=1, ralmost_empty=1, wfull=0.
REQ-035 Deassertion SHALL pass through a 2-flop synchroniser per domain; each domain resumes on the second rising edge of its own clock after rrst_n rises.
REQ-036 Reset mid-operation SHALL discard all contents; memory array is not cleared.

Verification (WIDTH=8, ADDRSIZE=4, AFULL_TH=12, AEMPTY_TH=2, SYNC_STAGES=2)
REQ-037 Reset, then write 0x00..0x0F -> wfull=1 the edge after 16th write, wlevel=16, walmost_full rose after 12th write; after sync rlevel=16, rempty=0.
REQ-038 17th write 0xAA while full -> woverflow=1, wlevel stays 16, later read order 0x00..0x0F with no 0xAA.
REQ-039 Read 16 words from full -> rdata 0x00..0x0F each with one rvalid pulse, rempty=1 after 16th, ralmost_empty=1 once rlevel<=2; rinc once more -> runderflow=1, rvalid=0.
REQ-040 wclk:rclk = 10ns:27ns, 200 random winc/rinc cycles -> scoreboard order exact, no loss or duplication, wlevel/rlevel never exceed 16.
REQ-041 Fill 40 words continuous streaming (pointer wraps twice) -> data intact, full/empty correct across MSB toggle.
REQ-042 Pulse rrst_n low with 9 words stored -> all outputs at reset values immediately; after release rempty=1, rlevel=0, first new write read back correctly.
